wb_trace_buffer: RTL and testbench

Write-back trace buffer that sits directly downstream of the single-cycle MIPS core. It captures every register-file write the core commits (PC, destination register, data), queues the events in a small FIFO, and drains them over a valid/ready stream to a debug consumer. Simulation benches and on-board debug logic then observe architectural state changes without probing `RF.registers` hierarchically. Writes to `$zero` are filtered out. Lost events are detectable through a sequence number and a saturating drop counter.

---
 rtl/wb_trace_buffer_if.sv | 49 ++++
 rtl/wb_trace_buffer.sv | 134 +++++++++++++
 tb/tb_wb_trace_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// wb_trace_buffer_if
//   Bundles the two streams around the write-back trace buffer:
//     - commit side  : wb_valid, wb_reg[4:0], wb_data[31:0], wb_pc[31:0]
//     - drain side   : out_valid, out_ready, out_pc[31:0], out_reg[4:0],
//                      out_data[31:0], out_seq[SEQ_W-1:0],
//                      out_time[31:0] (only with WB_TRACE_TIMESTAMP_EN)
//   Modports:
//     master : the environment (core + debug consumer); drives the commit
//              fields and out_ready, observes the drained entry.
//     slave  : the trace buffer itself.
//   Optional feature macro: WB_TRACE_TIMESTAMP_EN (adds out_time).
// ----------------------------------------------------------------------------
interface wb_trace_buffer_if #(
    parameter int SEQ_W = 16
);
    logic             wb_valid;
    logic [4:0]       wb_reg;
    logic [31:0]      wb_data;
    logic [31:0]      wb_pc;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       out_reg;
    logic [31:0]      out_data;
    logic [SEQ_W-1:0] out_seq;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0]      out_time;

    modport master (
        output wb_valid, wb_reg, wb_data, wb_pc, out_ready,
        input  out_valid, out_pc, out_reg, out_data, out_seq, out_time
    );
    modport slave (
        input  wb_valid, wb_reg, wb_data, wb_pc, out_ready,
        output out_valid, out_pc, out_reg, out_data, out_seq, out_time
    );
`else
    modport master (
        output wb_valid, wb_reg, wb_data, wb_pc, out_ready,
        input  out_valid, out_pc, out_reg, out_data, out_seq
    );
    modport slave (
        input  wb_valid, wb_reg, wb_data, wb_pc, out_ready,
        output out_valid, out_pc, out_reg, out_data, out_seq
    );
`endif
endinterface

// File: rtl/wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// wb_trace_buffer
//   Captures every committed register-file write of the single-cycle MIPS
//   core (PC, destination register, data), filters writes to $zero, queues
//   the events in a DEPTH-entry FIFO and drains them over a valid/ready
//   stream. Every non-$zero commit consumes a sequence number, accepted or
//   dropped, so gaps in out_seq reveal lost events.
//
//   Ports:
//     clk         in   core clock, rising edge
//     reset       in   synchronous, active-high; wins over push and pop
//     bus         if   wb_trace_buffer_if.slave (commit + drain streams)
//     overflow    out  sticky, set on any dropped event
//     drop_count  out  saturating count of dropped events
//     level       out  current FIFO occupancy (0..DEPTH)
//
//   Parameters: DEPTH (power of two, 2..64), SEQ_W (sequence width).
//   Optional feature macro: WB_TRACE_TIMESTAMP_EN -- adds a free-running
//   32-bit cycle counter whose value is stored with each entry and shown
//   on out_time.
// ----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    wb_trace_buffer_if.slave         bus,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [31:0]      stamp;
`endif
    } entry_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [SEQ_W-1:0] seq;
    logic             valid_q;
    logic [LW-1:0]    level_next;
    entry_t           head;
    entry_t           incoming;

    logic push_req;
    logic pop;
    logic full;
    logic push_ok;

    // $zero writes are invisible: no slot, no sequence number, no drop.
    assign push_req = bus.wb_valid && (bus.wb_reg != 5'd0);
    assign pop      = valid_q && bus.out_ready;
    assign full     = (level == FULL_LEVEL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req && (!full || pop);

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    always_comb begin
        incoming.pc   = bus.wb_pc;
        incoming.rd   = bus.wb_reg;
        incoming.data = bus.wb_data;
        incoming.seq  = seq;
`ifdef WB_TRACE_TIMESTAMP_EN
        incoming.stamp = cycle_cnt;
`endif
    end

    // NOTE: every path assigns level_next after a default, so no latch forms.
    always_comb begin
        level_next = level;
        if (push_ok && !pop)      level_next = level + LW'(1);
        else if (!push_ok && pop) level_next = level - LW'(1);
    end

    // NOTE: storage has no reset; pointers and level decide what is live.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wptr] <= incoming;
    end

    // NOTE: state registers use non-blocking assignment so all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            valid_q    <= 1'b0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_req) seq  <= seq + SEQ_W'(1);
            if (push_ok)  wptr <= wptr + AW'(1);
            if (pop)      rptr <= rptr + AW'(1);
            level   <= level_next;
            // No bypass: an entry pushed into an empty FIFO shows next cycle.
            valid_q <= (level_next != '0);
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    assign head          = mem[rptr];
    assign bus.out_valid = valid_q;
    // Fields read as zero while nothing is presented.
    assign bus.out_pc    = valid_q ? head.pc   : '0;
    assign bus.out_reg   = valid_q ? head.rd   : '0;
    assign bus.out_data  = valid_q ? head.data : '0;
    assign bus.out_seq   = valid_q ? head.seq  : '0;
`ifdef WB_TRACE_TIMESTAMP_EN
    assign bus.out_time  = valid_q ? head.stamp : '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_wb_trace_buffer
//   Self-checking bench for wb_trace_buffer (DEPTH=8, SEQ_W=16): a table of
//   per-cycle vectors for the basic push/pop/filter/reset behaviour, followed
//   by hand-written sequences for overflow, full push+pop, stalled handshake
//   and reset during a drain. Optional macro: WB_TRACE_TIMESTAMP_EN.
// ----------------------------------------------------------------------------
module tb_wb_trace_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        overflow;
    logic [15:0] drop_count;
    logic [3:0]  level;

    int tests_run = 0;
    int tests_failed = 0;

    wb_trace_buffer_if #(.SEQ_W(16)) bus ();

    wb_trace_buffer #(.DEPTH(8), .SEQ_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .overflow   (overflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] pc;
        logic        rdy;
        logic        e_valid;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic [15:0] e_seq;
        logic [3:0]  e_level;
        logic        e_ovf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock, then sample 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [4:0] rg,
                         input logic [31:0] data, input logic [31:0] pc, input logic rdy);
        reset         = rst;
        bus.wb_valid  = v;
        bus.wb_reg    = rg;
        bus.wb_data   = data;
        bus.wb_pc     = pc;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_seq [8];
    logic [4:0]  got_reg [$];
    logic        prev_stall;
    logic [31:0] held_pc, held_data;
    logic [4:0]  held_reg;
    logic [15:0] held_seq;

    initial begin
        // Vectors: inputs applied before an edge, expectations after it.
        vecs[0] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1,
                    1'b0, 5'd0,  32'h0,        32'h0,        16'd0, 4'd0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 5'd16, 32'h0000000A, 32'h00400000, 1'b1,
                    1'b1, 5'd16, 32'h0000000A, 32'h00400000, 16'd0, 4'd1, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1,
                    1'b0, 5'd0,  32'h0,        32'h0,        16'd0, 4'd0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1,
                    1'b0, 5'd0,  32'h0,        32'h0,        16'd0, 4'd0, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h00400000, 1'b1,
                    1'b0, 5'd0,  32'h0,        32'h0,        16'd0, 4'd0, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 1'b1, 5'd8,  32'h00000008, 32'h00400004, 1'b1,
                    1'b1, 5'd8,  32'h00000008, 32'h00400004, 16'd0, 4'd1, 1'b0, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0,
                    1'b1, 5'd8,  32'h00000008, 32'h00400004, 16'd0, 4'd1, 1'b0, 16'd0};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1,
                    1'b0, 5'd0,  32'h0,        32'h0,        16'd0, 4'd0, 1'b0, 16'd0};

        reset = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.wb_pc = '0;
        bus.out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rst, vecs[i].v, vecs[i].rg, vecs[i].data, vecs[i].pc, vecs[i].rdy);
            check($sformatf("vec%0d.valid", i), bus.out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d.reg", i),   bus.out_reg,   vecs[i].e_reg);
            check($sformatf("vec%0d.data", i),  bus.out_data,  vecs[i].e_data);
            check($sformatf("vec%0d.pc", i),    bus.out_pc,    vecs[i].e_pc);
            check($sformatf("vec%0d.seq", i),   bus.out_seq,   vecs[i].e_seq);
            check($sformatf("vec%0d.level", i), level,         vecs[i].e_level);
            check($sformatf("vec%0d.ovf", i),   overflow,      vecs[i].e_ovf);
            check($sformatf("vec%0d.drop", i),  drop_count,    vecs[i].e_drop);
        end

        // Overflow: 10 pushes into an 8-deep FIFO with the consumer stalled.
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b1, 5'(i + 1), 32'h100 + i, 32'h1000 + 4 * i, 1'b0);
        check("ovf.level", level, 4'd8);
        check("ovf.flag", overflow, 1'b1);
        check("ovf.drop", drop_count, 16'd2);
        check("ovf.head_seq", bus.out_seq, 16'd0);

        // Full with simultaneous push and pop: head (seq 0) leaves, seq 10 enters.
        check("fullpp.head_reg", bus.out_reg, 5'd1);
        cycle(1'b0, 1'b1, 5'd20, 32'h0000BEEF, 32'h2000, 1'b1);
        check("fullpp.level", level, 4'd8);
        check("fullpp.drop", drop_count, 16'd2);

        // Drain: seq 1..7 (gap 8,9 = drops) then 10.
        exp_seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd10};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.valid", i), bus.out_valid, 1'b1);
            check($sformatf("drain%0d.seq", i), bus.out_seq, exp_seq[i]);
            if (i < 7) check($sformatf("drain%0d.data", i), bus.out_data, 32'h100 + i + 1);
            else       check("drain7.data", bus.out_data, 32'h0000BEEF);
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        end
        check("drain.empty", bus.out_valid, 1'b0);
        check("drain.level", level, 4'd0);
        check("drain.ovf_sticky", overflow, 1'b1);

        // Burst of 4 with out_ready toggling; fields must hold while stalled.
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        prev_stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            reset         = 1'b0;
            bus.wb_valid  = (i < 4);
            bus.wb_reg    = 5'(i + 3);
            bus.wb_data   = 32'hA0 + i;
            bus.wb_pc     = 32'h3000 + 4 * i;
            bus.out_ready = (i % 2 == 0);
            if (prev_stall) begin
                check($sformatf("stall%0d.valid", i), bus.out_valid, 1'b1);
                check($sformatf("stall%0d.pc", i),   bus.out_pc,   held_pc);
                check($sformatf("stall%0d.reg", i),  bus.out_reg,  held_reg);
                check($sformatf("stall%0d.data", i), bus.out_data, held_data);
                check($sformatf("stall%0d.seq", i),  bus.out_seq,  held_seq);
            end
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("burst_seq%0d", got_reg.size()), bus.out_seq,
                      16'(got_reg.size()));
                got_reg.push_back(bus.out_reg);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_pc = bus.out_pc; held_reg = bus.out_reg;
            held_data = bus.out_data; held_seq = bus.out_seq;
            @(posedge clk);
            #1;
        end
        check("burst.count", got_reg.size(), 4);
        for (int i = 0; i < got_reg.size() && i < 4; i++)
            check($sformatf("burst.reg%0d", i), got_reg[i], 5'(i + 3));

        // Reset mid-drain with 5 entries queued and overflow set.
        for (int i = 0; i < 9; i++)
            cycle(1'b0, 1'b1, 5'd7, 32'h55 + i, 32'h4000, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("pre_rst.level", level, 4'd5);
        check("pre_rst.ovf", overflow, 1'b1);
        cycle(1'b1, 1'b1, 5'd9, 32'h1, 32'h1, 1'b1);
        check("rst.valid", bus.out_valid, 1'b0);
        check("rst.level", level, 4'd0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.drop", drop_count, 16'd0);
        check("rst.seq_field", bus.out_seq, 16'd0);

`ifdef WB_TRACE_TIMESTAMP_EN
        // Counter is 0 after the reset edge; three idle edges later it reads 3.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 5'd4, 32'h77, 32'h5000, 1'b0);
        check("ts.valid", bus.out_valid, 1'b1);
        check("ts.time", bus.out_time, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
